// File: rtl/clkgen_multi.sv
// clkgen_multi: multi-channel clock / clock-enable generator.
// A lock sequencer (RESET -> SETTLE -> LOCKED, RELOCK on reconfiguration)
// keeps every output low until the channel counters have been realigned
// and LOCK_CYCLES refclk cycles have passed. Each channel divides refclk by
// a run-time programmable ratio N with phase offset P.
// Optional readback of the clamped channel settings: define CLKGEN_RDBK_EN.
module clkgen_multi #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
`ifdef CLKGEN_RDBK_EN
  ,
  input  logic [2:0]        rd_ch,
  output logic [DIV_W-1:0]  rd_div,
  output logic [DIV_W-1:0]  rd_phase
`endif
);

  localparam int unsigned      NCH       = NUM_CH;
  localparam int               LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'((DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SETTLE,
    ST_LOCKED,
    ST_RELOCK
  } state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   lock_q, lock_d;
  logic             err_q, err_d;
  logic             accept;
  logic             align;
  logic             locked_d;
  logic             ch_ok;
  logic [DIV_W-1:0] new_div;
  logic [DIV_W-1:0] new_phase;

  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] phase_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [DIV_W:0]   half    [NUM_CH];

  logic [NUM_CH-1:0] outclk_q, outclk_d;
  logic [NUM_CH-1:0] en_q, en_d;

  assign ch_ok     = (32'(cfg_ch) < NCH);
  assign new_div   = (cfg_div == '0) ? ONE : cfg_div;
  assign new_phase = (cfg_phase >= new_div) ? (new_div - ONE) : cfg_phase;

  // Lock sequencer: next state, lock counter, config acceptance, error pulse.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_SETTLE;
        lock_d  = '0;
      end
      ST_SETTLE: begin
        if (lock_q == LOCK_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          lock_d = lock_q + LCW'(1);
        end
      end
      ST_LOCKED: begin
        if (cfg_valid) begin
          if (ch_ok) begin
            accept  = 1'b1;
            state_d = ST_RELOCK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RELOCK: begin
        state_d = ST_SETTLE;
        lock_d  = '0;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Leaving RESET or RELOCK is an alignment edge: every counter reloads.
  assign align    = (state_q == ST_RESET) || (state_q == ST_RELOCK);
  assign locked_d = (state_d == ST_LOCKED);

  // Sequencer state registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
      lock_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  // Channel settings (written clamped) and counter/output next values.
  // Outputs are registered from the next counter value so that outclk and
  // outclk_en line up with the counter in the same cycle.
  always_comb begin
    outclk_d = '0;
    en_d     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      if (accept && (32'(cfg_ch) == i)) begin
        div_d[i]   = new_div;
        phase_d[i] = new_phase;
      end
      if (align) begin
        cnt_d[i] = (phase_q[i] == '0) ? '0 : (div_q[i] - phase_q[i]);
      end else if (cnt_q[i] >= (div_q[i] - ONE)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
      half[i]     = ({1'b0, div_q[i]} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
      outclk_d[i] = locked_d && ({1'b0, cnt_d[i]} < half[i]);
      en_d[i]     = locked_d && (cnt_d[i] == '0);
    end
  end

  // Channel registers and registered outputs.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        div_q[i]   <= DEF_DIV;
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      outclk_q <= '0;
      en_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      outclk_q <= outclk_d;
      en_q     <= en_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign cfg_ready = (state_q == ST_LOCKED);
  assign cfg_err   = err_q;
  assign outclk    = outclk_q;
  assign outclk_en = en_q;

`ifdef CLKGEN_RDBK_EN
  logic [DIV_W-1:0] rd_div_q, rd_div_d;
  logic [DIV_W-1:0] rd_phase_q, rd_phase_d;

  // Readback mux; out-of-range channel reads as zero.
  always_comb begin
    rd_div_d   = '0;
    rd_phase_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(rd_ch) == i) begin
        rd_div_d   = div_q[i];
        rd_phase_d = phase_q[i];
      end
    end
  end

  // Readback register, one cycle of latency.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      rd_div_q   <= '0;
      rd_phase_q <= '0;
    end else begin
      rd_div_q   <= rd_div_d;
      rd_phase_q <= rd_phase_d;
    end
  end

  assign rd_div   = rd_div_q;
  assign rd_phase = rd_phase_q;
`endif

endmodule

// File: doc/clkgen_multi.md
Name: clkgen_multi

Overview:
- Parametrised multi-channel clock-enable generator. Successor to the single-output fixed-ratio PLL wrapper.
- Derives NUM_CH divided clocks, each with a matching one-cycle enable strobe, from refclk.
- Divide ratio and phase are programmable per channel at run time.
- A PLL-style lock sequencer holds all outputs off until the channels are aligned and settled. Sits between the board clock and downstream logic that needs slower strobes or clocks.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- DIV_W, 16, width of the divide and phase fields.
- DEFAULT_DIV, 5, divide ratio loaded into every channel at reset (50 MHz -> 10 MHz).
- LOCK_CYCLES, 16, refclk cycles from alignment to locked assertion (>=1).

Ports:
- refclk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted.
- cfg_ch  in  3  target channel index.
- cfg_div  in  DIV_W  new divide ratio N.
- cfg_phase  in  DIV_W  new phase offset P, in refclk cycles.
- cfg_err  out  1  one-cycle pulse: write addressed cfg_ch >= NUM_CH.
- outclk  out  NUM_CH  divided clocks, registered.
- outclk_en  out  NUM_CH  one-cycle enable strobes, registered.
- locked  out  1  all channels aligned and stable.

Behaviour:
- Reset (rst=0, async): state RESET. Outputs locked, outclk, outclk_en, cfg_err, cfg_ready all 0. Every channel N=DEFAULT_DIV, P=0.
- FSM states are RESET, SETTLE, LOCKED, RELOCK.
  - RESET -> SETTLE on the first refclk edge with rst=1. That edge is the alignment edge.
  - SETTLE: lock counter counts up. -> LOCKED after LOCK_CYCLES cycles.
  - LOCKED: cfg_ready=1. Accepted write (cfg_valid & cfg_ready) with a valid channel -> RELOCK.
  - RELOCK: lasts one cycle; locked=0, outputs forced 0. -> SETTLE; that edge is a new alignment edge.
- Timing reference: s = cycles since the last alignment edge; s=0 is the first cycle after it.
- locked=1 exactly when s >= LOCK_CYCLES and state is LOCKED.
- Channel clamping: N=0 is treated as 1. P >= N is clamped to N-1. Clamping is applied when the value is written into the channel register.
- Channel counter: loaded at alignment with (N-P) mod N, increments mod N, so cnt = (s-P) mod N.
- Channel outputs while locked:
  - outclk_en[i] = 1 when cnt==0.
  - outclk[i] = 1 when cnt < ceil(N/2).
  - N=1 gives outclk constantly 1 and outclk_en constantly 1.
  - Odd N: high phase is one cycle longer than the low phase.
- While not locked, outclk and outclk_en are 0, but counters keep running. Channels therefore come out of lock phase-coherent with each other.
- Config write:
  - Accepted only in LOCKED. Takes effect at the next alignment edge, not mid-period.
  - Only the addressed channel's N/P change.
  - cfg_ready drops the cycle after acceptance and returns when locked returns.
  - cfg_valid while cfg_ready=0 is ignored; no queuing.
- Invalid channel: cfg_ch >= NUM_CH while cfg_ready=1 -> cfg_err pulses 1 cycle. No register change, no relock, stays LOCKED.
- Reset mid-SETTLE or mid-RELOCK: immediate return to RESET values. Prior run-time config is lost; registers revert to DEFAULT_DIV and P=0.

Optional Feature:
- Macro CLKGEN_RDBK_EN.
- Defined: adds ports rd_ch (in, 3), rd_div (out, DIV_W) and rd_phase (out, DIV_W).
  - Return the clamped N and P of channel rd_ch, registered, 1-cycle latency.
  - rd_ch >= NUM_CH returns 0.
  - Readback reflects a write from the cycle after acceptance.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Defaults, NUM_CH=2, LOCK_CYCLES=16: release rst -> locked rises at s=16. outclk runs 3 high / 2 low. outclk_en pulses at s=20, 25, 30. Both channels identical.
- Write ch1 N=4 P=1 while locked -> cfg_ready and locked fall, relock, locked back 16 cycles after the new alignment edge. ch1 outclk_en pulses at s ≡ 1 mod 4 with a 2/2 duty. ch0 unchanged at N=5.
- Write ch0 N=0 P=7 -> behaves as N=1: outclk and outclk_en constantly 1 after lock.
- Write cfg_ch=5 with NUM_CH=2 -> cfg_err pulses 1 cycle; locked stays 1; outputs uninterrupted.
- Assert rst=0 at s=8 of a SETTLE following a config write -> all outputs 0 immediately. After release, both channels run N=5 P=0.
- CLKGEN_RDBK_EN defined: write ch1 N=6 P=9, then rd_ch=1 -> rd_div=6, rd_phase=5 one cycle later. rd_ch=3 -> 0/0.
